cpu4_mc_controller: RTL
=======================

# cpu4_mc_controller

Multicycle control FSM for the cpu4 core. It sequences a shared-ALU, unified-memory datapath one instruction at a time: fetch, decode, execute, memory, writeback. It handles a variable-latency memory through a req/ready handshake, flags unsupported opcodes, and counts retired instructions. It sits beside the multicycle datapath and drives all of its mux selects and write enables.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  access is a write; valid only with mem_req
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- irwrite  out  1  load the instruction register
- pcen  out  1  PC register enable
- pcsrc  out  2  00 = ALU result, 01 = ALUOut (branch), 10 = jump target
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = memory data register
- regwrite  out  1  register file write enable
- illegal  out  1  sticky: an unsupported op or funct has been decoded
- instret  out  32  retired-instruction counter

## Operation
- States, 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcen are asserted only on the cycle mem_ready=1, which is also the cycle the FSM moves to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else → FETCH, and set illegal
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next is FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready, then goes to FETCH.
- EXEC: alusrca=1, alusrcb=00. alucontrol comes from funct:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - any other funct → add, and set illegal
  - Next is ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
- JUMP: pcsrc=10, pcen=1. Next is FETCH.
- Default output values: any control not listed for a state is 0, except alucontrol, which defaults to add.
- Retirement:
  - instret increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - Illegal-op returns from DECODE do not count.
  - The counter wraps modulo 2^32.

## Timing
- Reset low: state=FETCH, illegal=0, instret=0, asynchronously.
  - While reset is low, mem_req, irwrite, pcen and regwrite are forced to 0.
  - The first request is issued in the first cycle after reset deasserts.
- Reset mid-access: the request drops immediately and no write enable pulses. The memory must tolerate an abandoned request.
- Outputs are combinational from state; irwrite, pcen, pcsrc-gated branch and the EXEC alucontrol also depend on inputs. No registered outputs except illegal and instret.
- Handshake:
  - A transfer occurs on a rising edge with mem_req=1 and mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - mem_req, iord and memwrite are held stable while waiting.
- Minimum latency with mem_ready tied high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - Each wait cycle adds 1.
- illegal is cleared only by reset.

## Structure
- Shared package/defines:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU control codes
  - alusrcb and pcsrc select codes
- One natural sub-module: cpu4_aludec (funct → alucontrol plus funct-illegal), purely combinational. The FSM, the illegal flag and instret live in the top module.

## Test plan
- Reset held low with mem_ready=1: all enables 0, instret=0. After release, mem_req=1 and iord=0 next cycle; irwrite and pcen pulse together.
- lw with op=100011 and mem_ready=1: states 0→1→2→3→4→0 in 5 cycles. regwrite=1 and memtoreg=1 in MEMWB; instret goes 0→1.
- sw with mem_ready low for 3 cycles in MEMWR: mem_req=1 and memwrite=1 held for 4 cycles. The FSM leaves on the ready edge; regwrite is never asserted.
- R-type with funct=101010: alucontrol=111 in EXEC, then regdst=1 and regwrite=1 in ALUWB. With funct=000111: illegal=1 and alucontrol=010.
- beq with zero=1: pcen=1 and pcsrc=01 in BRANCH. With zero=0: pcen=0. j gives pcen=1 and pcsrc=10. Both return to FETCH and increment instret.
- op=111111: DECODE→FETCH, illegal set and stays set, instret unchanged. Asserting reset during a stalled MEMRD returns to FETCH with illegal=0.

Source files
------------

// File: rtl/cpu4_mc_controller_pkg.sv
// Shared definitions for the cpu4 multicycle controller: state encoding,
// opcode/funct constants, ALU control codes and datapath select codes.
package cpu4_mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Loads and stores share the address-calculation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu4_mc_controller_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// drives every select and enable, and receives instruction fields, the ALU
// zero flag and the memory ready strobe.
//
// Memory handshake: mem_req acts as valid, mem_ready as ready. A transfer
// happens on a rising clk edge where mem_req=1 and mem_ready=1. mem_ready is
// ignored whenever mem_req=0. While waiting, mem_req, iord and memwrite stay
// stable; a request abandoned by reset simply disappears.
interface cpu4_mc_controller_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic        regdst;
    logic        memtoreg;
    logic        regwrite;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
               alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal,
               instret, state_dbg
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
               alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal,
               instret, state_dbg
    );
endinterface

// File: rtl/cpu4_mc_controller_aludec.sv
// R-type ALU decoder: maps funct to an ALU control code and flags functs the
// core does not implement (those fall back to add).
module cpu4_aludec
    import cpu4_mc_controller_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    // Pure lookup; unknown functs execute as add and raise illegal.
    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (funct)
            FUNCT_ADD: alucontrol = ALU_ADD;
            FUNCT_SUB: alucontrol = ALU_SUB;
            FUNCT_AND: alucontrol = ALU_AND;
            FUNCT_OR:  alucontrol = ALU_OR;
            FUNCT_SLT: alucontrol = ALU_SLT;
            default: begin
                alucontrol = ALU_ADD;
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu4_mc_controller.sv
// Multicycle control FSM for cpu4: fetch/decode/execute/memory/writeback
// sequencing, variable-latency memory handshake, sticky illegal-instruction
// flag and a retired-instruction counter.
module cpu4_mc_controller
    import cpu4_mc_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cpu4_mc_controller_if.master bus
);

    state_t      state;
    state_t      next_state;
    logic        illegal_q;
    logic [31:0] instret_q;

    logic        mem_req_c;
    logic        memwrite_c;
    logic        iord_c;
    logic        irwrite_c;
    logic        pcen_c;
    logic [1:0]  pcsrc_c;
    logic        alusrca_c;
    logic [1:0]  alusrcb_c;
    logic [2:0]  alucontrol_c;
    logic        regdst_c;
    logic        memtoreg_c;
    logic        regwrite_c;
    logic        set_illegal;
    logic        retire;

    logic [2:0]  funct_alu;
    logic        funct_bad;

    cpu4_aludec u_aludec (
        .funct      (bus.funct),
        .alucontrol (funct_alu),
        .illegal    (funct_bad)
    );

    // Next-state and control decode; outputs follow the current state, with
    // fetch enables, branch pcen and EXEC alucontrol also following inputs.
    always_comb begin
        next_state   = state;
        mem_req_c    = 1'b0;
        memwrite_c   = 1'b0;
        iord_c       = 1'b0;
        irwrite_c    = 1'b0;
        pcen_c       = 1'b0;
        pcsrc_c      = PCSRC_ALU;
        alusrca_c    = 1'b0;
        alusrcb_c    = SRCB_REG;
        alucontrol_c = ALU_ADD;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        regwrite_c   = 1'b0;
        set_illegal  = 1'b0;
        retire       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb_c = SRCB_FOUR;
                if (bus.mem_ready) begin
                    irwrite_c  = 1'b1;
                    pcen_c     = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb_c = SRCB_IMMSH;
                if (is_mem_op(bus.op)) begin
                    next_state = S_MEMADR;
                end else begin
                    case (bus.op)
                        OP_RTYPE: next_state = S_EXEC;
                        OP_BEQ:   next_state = S_BRANCH;
                        OP_ADDI:  next_state = S_ADDIEX;
                        OP_J:     next_state = S_JUMP;
                        default: begin
                            next_state  = S_FETCH;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = SRCB_IMM;
                next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = SRCB_REG;
                alucontrol_c = funct_alu;
                set_illegal  = funct_bad;
                next_state   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c    = 1'b1;
                alusrcb_c    = SRCB_REG;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = PCSRC_BRANCH;
                pcen_c       = bus.zero;
                retire       = 1'b1;
                next_state   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = SRCB_IMM;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c    = PCSRC_JUMP;
                pcen_c     = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // State register, sticky illegal flag and wrapping retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Reset is async, so state already reads FETCH while reset is low; the
    // request and all write enables are masked so nothing fires until release.
    assign bus.mem_req    = mem_req_c  & reset;
    assign bus.memwrite   = memwrite_c & reset;
    assign bus.irwrite    = irwrite_c  & reset;
    assign bus.pcen       = pcen_c     & reset;
    assign bus.regwrite   = regwrite_c & reset;
    assign bus.iord       = iord_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.regdst     = regdst_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.illegal    = illegal_q;
    assign bus.instret    = instret_q;
    assign bus.state_dbg  = state;

endmodule
